// File: rtl/sys_axi_pkg.sv
// Shared AXI encodings and the write-responder state type.
// Also provides the default for the `AXI_DATA_WIDTH` macro (64).
`ifndef AXI_DATA_WIDTH
`define AXI_DATA_WIDTH 64
`endif

package sys_axi_pkg;

  localparam logic [1:0] AXI_BURST_FIXED = 2'd0;
  localparam logic [1:0] AXI_BURST_INCR  = 2'd1;
  localparam logic [1:0] AXI_BURST_WRAP  = 2'd2;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'd0;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'd2;

  localparam int AXI_STRB_WIDTH = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DATA = 2'd1,
    ST_RESP = 2'd2
  } axi_wr_state_e;

  // A WRAP burst must cover 2, 4, 8 or 16 beats.
  function automatic logic wrap_len_legal(input logic [7:0] len);
    return (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
  endfunction

endpackage

// File: rtl/axi_wr_slave_if.sv
// AXI4 write-side channels (AW, W, B) bundled for the write responder.
interface axi_wr_slave_if #(
  parameter int ID_WIDTH   = 4,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 64
) ();

  logic [ID_WIDTH-1:0]   awid;
  logic [ADDR_WIDTH-1:0] awaddr;
  logic [7:0]            awlen;
  logic [2:0]            awsize;
  logic [1:0]            awburst;
  logic                  awvalid;
  logic                  awready;

  logic [DATA_WIDTH-1:0] wdata;
  logic [7:0]            wstrb;
  logic                  wlast;
  logic                  wvalid;
  logic                  wready;

  logic [ID_WIDTH-1:0]   bid;
  logic [1:0]            bresp;
  logic                  bvalid;
  logic                  bready;

  modport slave (
    input  awid, awaddr, awlen, awsize, awburst, awvalid,
    output awready,
    input  wdata, wstrb, wlast, wvalid,
    output wready,
    output bid, bresp, bvalid,
    input  bready
  );

  modport master (
    output awid, awaddr, awlen, awsize, awburst, awvalid,
    input  awready,
    output wdata, wstrb, wlast, wvalid,
    input  wready,
    input  bid, bresp, bvalid,
    output bready
  );

endinterface

// File: rtl/axi_burst_addr_gen.sv
// Combinational next-beat address for FIXED / INCR / WRAP bursts.
// WRAP support is compiled in only with `AXI_WR_SLAVE_WRAP_EN`; without it
// a WRAP burst keeps its address (the responder flags it as an error anyway).
module axi_burst_addr_gen
  import sys_axi_pkg::*;
#(
  parameter int ADDR_WIDTH = 32
) (
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  logic [2:0]            size_i,
  input  logic [7:0]            len_i,
  input  logic [1:0]            burst_i,
  output logic [ADDR_WIDTH-1:0] next_addr_o
);

  logic [ADDR_WIDTH-1:0] step;
  logic [ADDR_WIDTH-1:0] incr_addr;

  assign step      = ADDR_WIDTH'(1) << size_i;
  assign incr_addr = addr_i + step;

`ifdef AXI_WR_SLAVE_WRAP_EN
  // Wrap window is the whole burst footprint: (len+1) beats of 2^size bytes.
  logic [ADDR_WIDTH-1:0] mask;
  assign mask = ((ADDR_WIDTH'(len_i) + ADDR_WIDTH'(1)) << size_i) - ADDR_WIDTH'(1);

  // Select the next address by burst type, wrapping inside the window.
  always_comb begin
    next_addr_o = addr_i;
    case (burst_i)
      AXI_BURST_INCR: next_addr_o = incr_addr;
      AXI_BURST_WRAP: next_addr_o = (addr_i & ~mask) | (incr_addr & mask);
      default:        next_addr_o = addr_i;
    endcase
  end
`else
  logic unused_len;
  assign unused_len = ^len_i;

  // Select the next address by burst type; only INCR advances.
  always_comb begin
    next_addr_o = addr_i;
    if (burst_i == AXI_BURST_INCR) next_addr_o = incr_addr;
  end
`endif

endmodule

// File: rtl/axi_wr_slave.sv
// AXI4 write responder: one burst at a time, AW -> W beats -> B, driving a
// word-addressed SRAM write port. Malformed bursts are drained without
// writes and answered with SLVERR.
// Optional feature macro: AXI_WR_SLAVE_WRAP_EN (WRAP burst support).
module axi_wr_slave
  import sys_axi_pkg::*;
#(
  parameter int ID_WIDTH   = 4,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = `AXI_DATA_WIDTH   // strobe is 8 bits: 64 only
) (
  input  logic                  clk,
  input  logic                  rst,
  axi_wr_slave_if.slave         axi,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-4:0] mem_addr,
  output logic [63:0]           mem_wdata,
  output logic [7:0]            mem_wstrb,
  input  logic                  mem_ready
);

  axi_wr_state_e         state_q, state_d;
  logic [ID_WIDTH-1:0]   id_q, id_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [7:0]            len_q, len_d;
  logic [2:0]            size_q, size_d;
  logic [1:0]            burst_q, burst_d;
  logic [7:0]            cnt_q, cnt_d;
  logic                  err_q, err_d;

  logic                  awready, wready, bvalid;
  logic [ID_WIDTH-1:0]   bid;
  logic [1:0]            bresp;
  logic                  aw_err;
  logic                  last_cnt;
  logic [ADDR_WIDTH-1:0] next_addr;

  // Request-level errors are known at AW time.
`ifdef AXI_WR_SLAVE_WRAP_EN
  assign aw_err = (axi.awsize > 3'd3) || (axi.awburst == 2'd3) ||
                  ((axi.awburst == AXI_BURST_WRAP) && !wrap_len_legal(axi.awlen));
`else
  assign aw_err = (axi.awsize > 3'd3) || (axi.awburst == 2'd3) ||
                  (axi.awburst == AXI_BURST_WRAP);
`endif

  assign last_cnt = (cnt_q == len_q);

  axi_burst_addr_gen #(.ADDR_WIDTH(ADDR_WIDTH)) u_addr_gen (
    .addr_i      (addr_q),
    .size_i      (size_q),
    .len_i       (len_q),
    .burst_i     (burst_q),
    .next_addr_o (next_addr)
  );

  // Next-state and handshake outputs; everything held low while rst is high.
  always_comb begin
    state_d = state_q;
    id_d    = id_q;
    addr_d  = addr_q;
    len_d   = len_q;
    size_d  = size_q;
    burst_d = burst_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    awready = 1'b0;
    wready  = 1'b0;
    bvalid  = 1'b0;
    bid     = '0;
    bresp   = AXI_RESP_OKAY;
    mem_we  = 1'b0;
    if (!rst) begin
      case (state_q)
        ST_IDLE: begin
          awready = 1'b1;
          if (axi.awvalid) begin
            id_d    = axi.awid;
            addr_d  = axi.awaddr;
            len_d   = axi.awlen;
            size_d  = axi.awsize;
            burst_d = axi.awburst;
            cnt_d   = 8'd0;
            err_d   = aw_err;
            state_d = ST_DATA;
          end
        end
        ST_DATA: begin
          wready = mem_ready;
          if (axi.wvalid && mem_ready) begin
            // A beat is written only if the burst was clean before it.
            mem_we = !err_q;
            addr_d = next_addr;
            cnt_d  = cnt_q + 8'd1;
            if (axi.wlast != last_cnt) err_d = 1'b1;
            if (axi.wlast || last_cnt) state_d = ST_RESP;
          end
        end
        ST_RESP: begin
          bvalid = 1'b1;
          bid    = id_q;
          bresp  = err_q ? AXI_RESP_SLVERR : AXI_RESP_OKAY;
          if (axi.bready) state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Control state: reset drops any in-flight burst back to IDLE.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= 8'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  // Burst attributes and running address; only meaningful after an AW.
  always_ff @(posedge clk) begin
    id_q    <= id_d;
    addr_q  <= addr_d;
    len_q   <= len_d;
    size_q  <= size_d;
    burst_q <= burst_d;
  end

  assign axi.awready = awready;
  assign axi.wready  = wready;
  assign axi.bvalid  = bvalid;
  assign axi.bid     = bid;
  assign axi.bresp   = bresp;

  assign mem_addr  = addr_q[ADDR_WIDTH-1:3];
  assign mem_wdata = axi.wdata;
  assign mem_wstrb = axi.wstrb;

endmodule
